// File: rtl/stim_resp_harness.sv
// Closed-loop stimulus/response harness: a 9-bit LFSR drives a datapath input and a
// 28-bit MISR folds the returned responses into a signature.
module stim_resp_harness #(
    parameter int          NUM_VECTORS = 256,
    parameter logic [8:0]  SEED        = 9'h001,
    parameter logic [27:0] MISR_SEED   = 28'h0000000,
    parameter int          RESP_LAT    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hold,
    output logic [8:0]  stim_data,
    output logic        stim_valid,
    input  logic [27:0] resp_data,
    output logic        busy,
    output logic        done,
    output logic [27:0] signature,
    output logic [8:0]  vec_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // An all-zero LFSR would lock up, so a zero seed falls back to 1.
    localparam logic [8:0] SEED_N = (SEED == 9'h000) ? 9'h001 : SEED;
    localparam logic [8:0] LAST   = 9'(NUM_VECTORS - 1);
    localparam int         PL     = (RESP_LAT == 0) ? 1 : RESP_LAT;

    // Handshake: a vector is issued at every rising edge where stim_valid=1 and hold=0;
    // its response is expected on resp_data RESP_LAT cycles later, with no back-pressure.
    logic [1:0]    state;
    logic [8:0]    issue_cnt;
    logic [PL-1:0] vpipe;
    logic [PL-1:0] vpipe_next;
    logic          issue;
    logic          last_issue;
    logic          capture;
    logic [8:0]    lfsr_next;
    logic [27:0]   misr_next;

    assign stim_valid = (state == ST_RUN);
    assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);

    assign issue      = stim_valid && !hold;
    assign last_issue = issue && (issue_cnt == LAST);
    assign capture    = (RESP_LAT == 0) ? issue : (vpipe[PL-1] && busy);

    assign lfsr_next  = {stim_data[7:0], stim_data[8] ^ stim_data[4]};
    assign misr_next  = {signature[26:0], signature[27] ^ signature[24]} ^ resp_data;
    assign vpipe_next = (vpipe << 1) | PL'(issue);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            stim_data <= SEED_N;
            signature <= MISR_SEED;
            vec_count <= 9'd0;
            issue_cnt <= 9'd0;
            vpipe     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        stim_data <= SEED_N;
                        signature <= MISR_SEED;
                        vec_count <= 9'd0;
                        issue_cnt <= 9'd0;
                        vpipe     <= '0;
                    end
                end
                ST_RUN: begin
                    vpipe <= vpipe_next;
                    if (issue) begin
                        stim_data <= lfsr_next;
                        issue_cnt <= issue_cnt + 9'd1;
                        if (last_issue) begin
                            state <= (RESP_LAT == 0) ? ST_DONE : ST_DRAIN;
                        end
                    end
                    if (capture) begin
                        signature <= misr_next;
                        vec_count <= vec_count + 9'd1;
                    end
                end
                ST_DRAIN: begin
                    vpipe <= vpipe_next;
                    if (capture) begin
                        signature <= misr_next;
                        vec_count <= vec_count + 9'd1;
                        if (vec_count == LAST) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stim_resp_harness.sv
// Bench for stim_resp_harness: three configurations covering zero latency, a short
// registered response with hold/reset corners, and a randomized run against a model.
module tb_stim_resp_harness;

    localparam int          C_N    = 20;
    localparam int          C_L    = 3;
    localparam logic [8:0]  C_SEED = 9'h1B3;
    localparam logic [27:0] C_MISR = 28'h5A5A5A5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // DUT A: zero seed, 6 vectors, combinational response selected by mode_a
    logic        start_a, hold_a;
    logic [1:0]  mode_a;
    logic [8:0]  stim_a, cnt_a;
    logic [27:0] resp_a, sig_a;
    logic        valid_a, busy_a, done_a;
    logic [8:0]  seen_a[$];

    // DUT B: 4 vectors, two-cycle response latency, constant response of 1
    logic        start_b, hold_b;
    logic [8:0]  stim_b, cnt_b;
    logic [27:0] sig_b;
    logic        valid_b, busy_b, done_b;

    // DUT C: randomized holds, three-stage registered datapath
    logic        start_c, hold_c;
    logic [8:0]  stim_c, cnt_c, d1, d2, d3;
    logic [27:0] resp_c, sig_c;
    logic        valid_c, busy_c, done_c;
    logic [8:0]  exp_q[$];

    function automatic logic [27:0] resp_fn(input logic [8:0] x);
        return {1'b0, x, x ^ 9'h155, x + 9'd7};
    endfunction

    always_comb begin
        resp_a = 28'h0;
        case (mode_a)
            2'd1:    resp_a = 28'h1;
            2'd2:    resp_a = {19'b0, stim_a};
            default: resp_a = 28'h0;
        endcase
    end

    always @(posedge clk) begin
        d1 <= stim_c;
        d2 <= d1;
        d3 <= d2;
    end
    assign resp_c = resp_fn(d3);

    stim_resp_harness #(.NUM_VECTORS(6), .SEED(9'h000), .MISR_SEED(28'h0), .RESP_LAT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .hold(hold_a), .stim_data(stim_a),
        .stim_valid(valid_a), .resp_data(resp_a), .busy(busy_a), .done(done_a),
        .signature(sig_a), .vec_count(cnt_a));

    stim_resp_harness #(.NUM_VECTORS(4), .SEED(9'h001), .MISR_SEED(28'h0), .RESP_LAT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .hold(hold_b), .stim_data(stim_b),
        .stim_valid(valid_b), .resp_data(28'h1), .busy(busy_b), .done(done_b),
        .signature(sig_b), .vec_count(cnt_b));

    stim_resp_harness #(.NUM_VECTORS(C_N), .SEED(C_SEED), .MISR_SEED(C_MISR), .RESP_LAT(C_L)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .hold(hold_c), .stim_data(stim_c),
        .stim_valid(valid_c), .resp_data(resp_c), .busy(busy_c), .done(done_c),
        .signature(sig_c), .vec_count(cnt_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_a(output int cycles);
        seen_a.delete();
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("a_start_cnt", 32'(cnt_a), 32'd0);
        check("a_start_sig", 32'(sig_a), 32'd0);
        check("a_start_done", 32'(done_a), 32'd0);
        cycles = 0;
        while (!done_a && cycles < 200) begin
            if (valid_a) seen_a.push_back(stim_a);
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic run_b(input int hold_at, input int hold_len, input bit mid_start,
                         output int cycles, output int drains, output bit frozen_ok);
        int issued = 0;
        int held = 0;
        logic [8:0] hv;
        frozen_ok = 1'b1;
        drains = 0;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        cycles = 0;
        while (!done_b && cycles < 200) begin
            start_b = mid_start && (cycles == 2);
            hold_b = 1'b0;
            if (valid_b) begin
                if (issued == hold_at && held < hold_len) begin
                    hold_b = 1'b1;
                    held++;
                end else begin
                    issued++;
                end
            end
            if (busy_b && !valid_b) drains++;
            hv = stim_b;
            @(posedge clk);
            #1;
            cycles++;
            if (hold_b && stim_b !== hv) frozen_ok = 1'b0;
        end
        hold_b = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic run_c(input int pct);
        logic [8:0]  x;
        logic [27:0] m;
        int holds = 0;
        int issued = 0;
        int cycles = 0;
        exp_q.delete();
        x = C_SEED;
        m = C_MISR;
        for (int i = 0; i < C_N; i++) begin
            exp_q.push_back(x);
            m = {m[26:0], m[27] ^ m[24]} ^ resp_fn(x);
            x = {x[7:0], x[8] ^ x[4]};
        end
        @(negedge clk);
        start_c = 1'b1;
        @(posedge clk);
        #1;
        start_c = 1'b0;
        while (!done_c && cycles < 500) begin
            hold_c = 1'b0;
            if (valid_c) begin
                hold_c = ($urandom_range(0, 99) < pct);
                if (hold_c) holds++;
                else begin
                    issued++;
                    if (exp_q.size() > 0) check("c_stim", 32'(stim_c), 32'(exp_q.pop_front()));
                end
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        hold_c = 1'b0;
        check("c_cycles", 32'(cycles), 32'(C_N + C_L + holds));
        check("c_issued", 32'(issued), 32'(C_N));
        check("c_sig", 32'(sig_c), 32'(m));
        check("c_cnt", 32'(cnt_c), 32'(C_N));
        repeat (4) @(posedge clk);
        #1;
        check("c_sig_stable", 32'(sig_c), 32'(m));
        check("c_done_stable", 32'(done_c), 32'd1);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [27:0] exp_sig;
        logic [8:0]  exp_cnt;
        int          exp_cyc;
    } vec_t;

    initial begin
        vec_t tbl[3];
        logic [8:0] exp_stim[6];
        int cyc, drains;
        bit frozen;

        tbl[0] = '{2'd0, 28'h0000000, 9'd6, 6};
        tbl[1] = '{2'd1, 28'h000003F, 9'd6, 6};
        tbl[2] = '{2'd2, 28'h0000001, 9'd6, 6};
        exp_stim = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h021};

        rst_n = 1'b0;
        start_a = 1'b0; hold_a = 1'b0; mode_a = 2'd0;
        start_b = 1'b0; hold_b = 1'b0;
        start_c = 1'b0; hold_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stim", 32'(stim_a), 32'h001);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_cnt", 32'(cnt_a), 32'd0);
        check("rst_sig_c", 32'(sig_c), 32'(C_MISR));
        check("rst_stim_c", 32'(stim_c), 32'(C_SEED));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            mode_a = tbl[i].mode;
            run_a(cyc);
            check("a_cycles", 32'(cyc), 32'(tbl[i].exp_cyc));
            check("a_sig", 32'(sig_a), 32'(tbl[i].exp_sig));
            check("a_cnt", 32'(cnt_a), 32'(tbl[i].exp_cnt));
            check("a_valid_done", 32'(valid_a), 32'd0);
            check("a_nstim", 32'(seen_a.size()), 32'd6);
            for (int k = 0; k < 6 && k < seen_a.size(); k++)
                check("a_stim_seq", 32'(seen_a[k]), 32'(exp_stim[k]));
        end

        run_b(-1, 0, 1'b0, cyc, drains, frozen);
        check("b_cycles", 32'(cyc), 32'd6);
        check("b_drain", 32'(drains), 32'd2);
        check("b_sig", 32'(sig_b), 32'h000000F);
        check("b_cnt", 32'(cnt_b), 32'd4);

        run_b(2, 3, 1'b0, cyc, drains, frozen);
        check("b_hold_cycles", 32'(cyc), 32'd9);
        check("b_hold_sig", 32'(sig_b), 32'h000000F);
        check("b_hold_frozen", 32'(frozen), 32'd1);

        run_b(-1, 0, 1'b1, cyc, drains, frozen);
        check("b_midstart_cycles", 32'(cyc), 32'd6);
        check("b_midstart_sig", 32'(sig_b), 32'h000000F);

        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("b_pre_rst_sig", 32'(sig_b), 32'h1);
        rst_n = 1'b0;
        #1;
        check("b_rst_stim", 32'(stim_b), 32'h001);
        check("b_rst_valid", 32'(valid_b), 32'd0);
        check("b_rst_busy", 32'(busy_b), 32'd0);
        check("b_rst_done", 32'(done_b), 32'd0);
        check("b_rst_sig", 32'(sig_b), 32'h0);
        check("b_rst_cnt", 32'(cnt_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_b(-1, 0, 1'b0, cyc, drains, frozen);
        check("b_after_rst_cycles", 32'(cyc), 32'd6);
        check("b_after_rst_sig", 32'(sig_b), 32'h000000F);

        run_c(0);
        run_c(40);
        run_c(75);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
